// File: rtl/sha256_msg_sched_pkg.sv
// Shared types, constants and sigma helpers for the SHA-256 message schedule.
// Optional feature macro used by the other files: SHA256_SCHED_TIDX_EN.
package sha256_msg_sched_pkg;

    localparam int SHA256_WORDS  = 32'sd16;
    localparam int SHA256_ROUNDS = 32'sd64;
    localparam int WORD_W        = 32'sd32;
    localparam int TIDX_W        = 32'sd6;
    localparam int BLOCK_W       = SHA256_WORDS * WORD_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [TIDX_W-1:0] tidx_t;

    localparam tidx_t T_LAST = 6'd63;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Small sigma functions of the schedule recurrence (rotations as wire swaps).
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Schedule-word stream towards the round adder; t_idx exists only when
// SHA256_SCHED_TIDX_EN is defined.
interface sha256_msg_sched_if;
    import sha256_msg_sched_pkg::*;

    word_t w_out;
    logic  w_valid;
    logic  w_ready;
`ifdef SHA256_SCHED_TIDX_EN
    tidx_t t_idx;

    modport master (output w_out, output w_valid, output t_idx, input w_ready);
    modport slave  (input  w_out, input  w_valid, input  t_idx, output w_ready);
`else
    modport master (output w_out, output w_valid, input w_ready);
    modport slave  (input  w_out, input  w_valid, output w_ready);
`endif

endinterface

// File: rtl/sha256_msg_sched_add4.sv
// 32-bit four-operand modular adder; carries out of bit 31 are dropped.
module sha256_msg_sched_add4
    import sha256_msg_sched_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    output word_t sum_o
);

    assign sum_o = a_i + b_i + c_i + d_i;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams W0..W63 of one 512-bit block with a
// valid/ready handshake. Macro SHA256_SCHED_TIDX_EN adds the t_idx output.
module sha256_msg_sched
    import sha256_msg_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   block_in,
    output logic                 busy,
    output logic                 done,
    sha256_msg_sched_if.master   ws
);

    state_e state_q, state_d;
    word_t  win_q [SHA256_WORDS];
    word_t  win_d [SHA256_WORDS];
    tidx_t  t_q, t_d;
    word_t  w_out_q, w_out_d;
    logic   w_valid_q, w_valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    word_t  new_word_s;
    logic   hs_s;
`ifdef SHA256_SCHED_TIDX_EN
    tidx_t  t_idx_q, t_idx_d;
`endif

    assign hs_s = w_valid_q & ws.w_ready;

    sha256_msg_sched_add4 u_add4 (
        .a_i   (sigma1(win_q[14])),
        .b_i   (win_q[9]),
        .c_i   (sigma0(win_q[1])),
        .d_i   (win_q[0]),
        .sum_o (new_word_s)
    );

    // Next-state logic: load on start, shift the window on each handshake.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        t_d       = t_q;
        w_valid_d = w_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < SHA256_WORDS; i++) begin
                        win_d[i] = block_in[(SHA256_WORDS - 1 - i) * WORD_W +: WORD_W];
                    end
                    t_d       = 6'd0;
                    w_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    w_valid_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (hs_s) begin
                    for (int i = 0; i < SHA256_WORDS - 1; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[SHA256_WORDS - 1] = new_word_s;
                    // The final handshake ends the block instead of wrapping t.
                    if (t_q == T_LAST) begin
                        state_d   = ST_IDLE;
                        t_d       = 6'd0;
                        w_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                t_d       = 6'd0;
                w_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
        w_out_d = w_valid_d ? win_d[0] : 32'd0;
`ifdef SHA256_SCHED_TIDX_EN
        t_idx_d = w_valid_d ? t_d : 6'd0;
`endif
    end

    // State, window and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < SHA256_WORDS; i++) begin
                win_q[i] <= 32'd0;
            end
            t_q       <= 6'd0;
            w_out_q   <= 32'd0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHA256_SCHED_TIDX_EN
            t_idx_q   <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            t_q       <= t_d;
            w_out_q   <= w_out_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SHA256_SCHED_TIDX_EN
            t_idx_q   <= t_idx_d;
`endif
        end
    end

    assign ws.w_out   = w_out_q;
    assign ws.w_valid = w_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SHA256_SCHED_TIDX_EN
    assign ws.t_idx   = t_idx_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched against a textbook W[t] reference model;
// t_idx is also checked when SHA256_SCHED_TIDX_EN is defined.
module tb_sha256_msg_sched;
    import sha256_msg_sched_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic         done;

    sha256_msg_sched_if ws();

    sha256_msg_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .block_in (block_in),
        .busy     (busy),
        .done     (done),
        .ws       (ws)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] obs [64];
    int          checks = 0;
    int          errors = 0;
    int          mode = 0;
    int          hs_cnt = 0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom();
        return b;
    endfunction

    // Reference model: full 64-entry schedule, pushed onto the scoreboard.
    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        exp_t        e;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.w    = w[t];
            e.idx  = 6'(t);
            e.last = (t == 63);
            exp_q.push_back(e);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = random plus a 20-cycle stall at t=16.
    initial begin
        ws.w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) begin
                ws.w_ready = 1'b1;
            end else if (mode == 2 && hs_cnt == 16 && stall_cnt < 20) begin
                ws.w_ready = 1'b0;
                stall_cnt++;
            end else begin
                if (hs_cnt != 16) stall_cnt = 0;
                ws.w_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks cycle-level rules.
    initial begin
        exp_t        e;
        logic        exp_done_next = 1'b0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_out = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done_next = 1'b0;
                prev_stall    = 1'b0;
            end else begin
                chk("done", 32'(done), 32'(exp_done_next));
                chk("busy", 32'(busy), 32'(ws.w_valid));
                if (prev_stall) begin
                    chk("stall_valid", 32'(ws.w_valid), 32'd1);
                    chk("stall_hold", ws.w_out, prev_out);
                end
                exp_done_next = 1'b0;
                if (!ws.w_valid) begin
                    chk("w_out_idle", ws.w_out, 32'd0);
`ifdef SHA256_SCHED_TIDX_EN
                    chk("t_idx_idle", 32'(ws.t_idx), 32'd0);
`endif
                end else if (ws.w_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word at %0t", ws.w_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("w_out", ws.w_out, e.w);
`ifdef SHA256_SCHED_TIDX_EN
                        chk("t_idx", 32'(ws.t_idx), 32'(e.idx));
`endif
                        obs[e.idx]    = ws.w_out;
                        hs_cnt        = int'(e.idx) + 1;
                        exp_done_next = e.last;
                    end
                end
                prev_stall = ws.w_valid && !ws.w_ready;
                prev_out   = ws.w_out;
            end
        end
    end

    // Issue one block, optionally releasing reset on the same edge; returns cycles to done.
    task automatic run_block(input logic [511:0] blk, input int m, input bit release_rst, output int cyc);
        bit seen;
        push_block(blk);
        @(negedge clk);
        mode     = m;
        start    = 1'b1;
        block_in = blk;
        if (release_rst) rst_n = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 3000 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_valid", 32'(ws.w_valid), 32'd1);
                start    = 1'b0;
                block_in = rand_block();
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (!seen) exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        int           cyc;
        bit           seen;

        abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        rst_n    = 1'b0;
        start    = 1'b0;
        block_in = 512'd0;

        #12;
        chk("rst_w_valid", 32'(ws.w_valid), 32'd0);
        chk("rst_w_out", ws.w_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // "abc" block, start on the very edge after reset release.
        run_block(abc, 0, 1'b1, cyc);
        chk("abc_done_cycle", 32'(cyc), 32'd65);
        chk("abc_W0", obs[0], 32'h61626380);
        chk("abc_W15", obs[15], 32'h00000018);
        chk("abc_W16", obs[16], 32'h61626380);
        chk("abc_W17", obs[17], 32'h000F0000);

        run_block(512'd0, 0, 1'b0, cyc);
        chk("zero_done_cycle", 32'(cyc), 32'd65);
        chk("zero_W63", obs[63], 32'd0);

        run_block(abc, 2, 1'b0, cyc);
        chk("stall_abc_W17", obs[17], 32'h000F0000);

        for (int n = 0; n < 3; n++) begin
            run_block(rand_block(), 1, 1'b0, cyc);
        end

        // start held high through RUN and into the done cycle.
        blk_a = rand_block();
        blk_b = rand_block();
        push_block(blk_a);
        push_block(blk_b);
        @(negedge clk);
        mode     = 0;
        start    = 1'b1;
        block_in = blk_a;
        @(negedge clk);
        block_in = blk_b;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("b2b_first_done", 32'(cyc), 32'd64);
        chk("b2b_bubble", 32'(ws.w_valid), 32'd0);
        @(negedge clk);
        chk("b2b_second_start", 32'(ws.w_valid), 32'd1);
        start    = 1'b0;
        block_in = rand_block();
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk("b2b_second_done", 32'(cyc), 32'd64);
        repeat (3) begin
            @(negedge clk);
            chk("b2b_no_third", 32'(ws.w_valid), 32'd0);
        end
        chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset while W30 is presented: block is abandoned without done.
        push_block(abc);
        @(negedge clk);
        start    = 1'b1;
        block_in = abc;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (hs_cnt != 30 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk("reached_t30", 32'(hs_cnt), 32'd30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_w_valid", 32'(ws.w_valid), 32'd0);
        chk("arst_w_out", ws.w_out, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
`ifdef SHA256_SCHED_TIDX_EN
        chk("arst_t_idx", 32'(ws.t_idx), 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        run_block({16{32'hFFFFFFFF}}, 0, 1'b1, cyc);
        chk("ones_done_cycle", 32'(cyc), 32'd65);
        chk("ones_W0", obs[0], 32'hFFFFFFFF);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
